// File: rtl/serial_mux_tx_pkg.sv
// Shared definitions for the serial port-demux link (transmitter and receiver datapath).
package serial_mux_tx_pkg;

  localparam int   PORT_W_DEF   = 2;
  localparam int   CNT_W_DEF    = 4;
  localparam logic IDLE_LVL_DEF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_PORT   = 3'd2,
    ST_COUNT  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5
  } tx_state_e;

endpackage

// File: rtl/serial_mux_tx_shift_reg.sv
// Payload shift register: parallel load, right shift on enable, async reset.
// Exposes the two bits nearest the line so the caller can register the next bit.
module tx_shift_reg #(
  parameter int W = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         shift_en,
  output logic [1:0]   head
);

  logic [W-1:0] q_r;

  // load has priority over shift; zeros enter from the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {W{1'b0}};
    end else if (load) begin
      q_r <= d;
    end else if (shift_en) begin
      q_r <= {1'b0, q_r[W-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign head = q_r[1:0];

endmodule

// File: rtl/serial_mux_tx.sv
// Serial mux transmitter: frame = {start, port MSB-first, count MSB-first, data LSB-first}.
// Optional macro TX_PARITY_EN appends one even-parity bit over port, count and data.
module serial_mux_tx
  import serial_mux_tx_pkg::*;
#(
  parameter int   PORT_W   = PORT_W_DEF,
  parameter int   CNT_W    = CNT_W_DEF,
  parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Clk_EN,
  input  logic                  start,
  input  logic [PORT_W-1:0]     port_sel,
  input  logic [CNT_W-1:0]      len,
  input  logic [2**CNT_W-2:0]   payload,
  output logic                  SerOut,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      remain
);

  localparam int               PAY_W    = 2**CNT_W - 1;
  localparam int               HDR_W    = PORT_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  tx_state_e         state_r;
  logic [HDR_W-1:0]  hdr_r;
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  idx_r;
  logic [1:0]        head_s;
  logic              load_s;
  logic              shift_s;
  logic              end_s;

`ifdef TX_PARITY_EN
  logic par_r;

  function automatic logic frame_parity(input logic [PORT_W-1:0] p,
                                        input logic [CNT_W-1:0]  n,
                                        input logic [PAY_W-1:0]  d);
    logic acc;
    acc = (^p) ^ (^n);
    for (int i = 0; i < PAY_W; i++) begin
      if (i < int'(n)) acc = acc ^ d[i];
    end
    return acc;
  endfunction
`endif

  assign load_s  = (state_r == ST_IDLE) && start;
  assign shift_s = (state_r == ST_DATA) && Clk_EN;
  // last data/count bit finishing its step
  assign end_s   = Clk_EN &&
                   (((state_r == ST_COUNT) && (idx_r == CNT_ZERO) && (len_r == CNT_ZERO)) ||
                    ((state_r == ST_DATA) && (remain == CNT_ONE)));

  tx_shift_reg #(.W(PAY_W)) u_payload (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .d        (payload),
    .shift_en (shift_s),
    .head     (head_s)
  );

  // Frame sequencer; SerOut is registered with the bit that the new state sends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      hdr_r   <= {HDR_W{1'b0}};
      len_r   <= CNT_ZERO;
      idx_r   <= CNT_ZERO;
      SerOut  <= IDLE_LVL;
      busy    <= 1'b0;
      done    <= 1'b0;
      remain  <= CNT_ZERO;
`ifdef TX_PARITY_EN
      par_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (end_s) begin
        remain <= CNT_ZERO;
`ifdef TX_PARITY_EN
        state_r <= ST_PARITY;
        SerOut  <= par_r;
`else
        state_r <= ST_IDLE;
        SerOut  <= IDLE_LVL;
        busy    <= 1'b0;
        done    <= 1'b1;
`endif
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (start) begin
              state_r <= ST_START;
              hdr_r   <= {port_sel, len};
              len_r   <= len;
              busy    <= 1'b1;
              SerOut  <= ~IDLE_LVL;
`ifdef TX_PARITY_EN
              par_r   <= frame_parity(port_sel, len, payload);
`endif
            end
          end
          ST_START: begin
            if (Clk_EN) begin
              state_r <= ST_PORT;
              idx_r   <= CNT_W'(PORT_W - 1);
              SerOut  <= hdr_r[HDR_W-1];
            end
          end
          ST_PORT: begin
            if (Clk_EN) begin
              hdr_r  <= {hdr_r[HDR_W-2:0], 1'b0};
              SerOut <= hdr_r[HDR_W-2];
              if (idx_r == CNT_ZERO) begin
                state_r <= ST_COUNT;
                idx_r   <= CNT_W'(CNT_W - 1);
              end else begin
                idx_r <= idx_r - CNT_ONE;
              end
            end
          end
          ST_COUNT: begin
            if (Clk_EN) begin
              hdr_r <= {hdr_r[HDR_W-2:0], 1'b0};
              if (idx_r != CNT_ZERO) begin
                idx_r  <= idx_r - CNT_ONE;
                SerOut <= hdr_r[HDR_W-2];
              end else begin
                state_r <= ST_DATA;
                remain  <= len_r;
                SerOut  <= head_s[0];
              end
            end
          end
          ST_DATA: begin
            if (Clk_EN) begin
              remain <= remain - CNT_ONE;
              SerOut <= head_s[1];
            end
          end
`ifdef TX_PARITY_EN
          ST_PARITY: begin
            if (Clk_EN) begin
              state_r <= ST_IDLE;
              SerOut  <= IDLE_LVL;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
`endif
          default: begin
            state_r <= ST_IDLE;
            SerOut  <= IDLE_LVL;
            busy    <= 1'b0;
            remain  <= CNT_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_mux_tx.sv
// Bench for serial_mux_tx: frame-list model checked every cycle plus directed literal frames.
module tb_serial_mux_tx;

  typedef bit bitq_t[$];

  logic        clk;
  logic        rst;
  logic        Clk_EN;
  logic        start;
  logic [1:0]  port_sel;
  logic [3:0]  len;
  logic [14:0] payload;
  logic        SerOut;
  logic        busy;
  logic        done;
  logic [3:0]  remain;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  // model state: the frame as a list of line levels and the position on it
  bitq_t m_fb;
  int    m_pos  = 0;
  int    m_len  = 0;
  bit    m_busy = 1'b0;
  bit    m_done = 1'b0;

  serial_mux_tx dut (
    .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .start(start), .port_sel(port_sel),
    .len(len), .payload(payload), .SerOut(SerOut), .busy(busy), .done(done),
    .remain(remain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bitq_t make_frame(input logic [1:0] p, input logic [3:0] n,
                                       input logic [14:0] d);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 1; i >= 0; i--) q.push_back(p[i]);
    for (int i = 3; i >= 0; i--) q.push_back(n[i]);
    for (int i = 0; i < int'(n); i++) q.push_back(d[i]);
`ifdef TX_PARITY_EN
    begin
      bit par;
      par = 1'b0;
      for (int i = 1; i < q.size(); i++) par = par ^ q[i];
      q.push_back(par);
    end
`endif
    return q;
  endfunction

  // model update on each edge, then compare just after it
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 1'b0; m_done = 1'b0; m_pos = 0; m_len = 0;
      end else begin
        m_done = 1'b0;
        if (!m_busy) begin
          if (start) begin
            m_fb   = make_frame(port_sel, len, payload);
            m_len  = int'(len);
            m_pos  = 0;
            m_busy = 1'b1;
          end
        end else if (Clk_EN) begin
          m_pos++;
          if (m_pos == m_fb.size()) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            n_frames++;
          end
        end
      end
      #1;
      check("m_serout", 32'(SerOut), 32'(m_busy ? m_fb[m_pos] : 1'b1));
      check("m_busy",   32'(busy),   32'(m_busy));
      check("m_done",   32'(done),   32'(m_done));
      check("m_remain", 32'(remain),
            (m_busy && m_pos >= 7 && m_pos < 7 + m_len) ? 32'(m_len - (m_pos - 7)) : 32'd0);
    end
  end

  task automatic pulse(input int max_gap);
    Clk_EN = 1'b1;
    @(negedge clk);
    Clk_EN = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    int g;
    g = $urandom_range(0, max_gap);
    for (int i = 0; i < g; i++) @(negedge clk);
  endtask

  // send one frame and check each line level before its step against a hand list
  task automatic directed(input string nm, input logic [1:0] p, input logic [3:0] n,
                          input logic [14:0] d, input bitq_t exp);
    port_sel = p; len = n; payload = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < exp.size(); k++) begin
      check({nm, "_bit"}, 32'(SerOut), 32'(exp[k]));
      if (k == 7 && n != 4'd0) check({nm, "_remain_first"}, 32'(remain), 32'(n));
      pulse(0);
      check({nm, "_done"}, 32'(done), (k == exp.size() - 1) ? 32'd1 : 32'd0);
      if (k != exp.size() - 1) gap(2);
    end
    check({nm, "_remain_end"}, 32'(remain), 32'd0);
    @(negedge clk);
    check({nm, "_done_once"}, 32'(done), 32'd0);
    check({nm, "_idle"}, 32'(busy), 32'd0);
    check({nm, "_idle_lvl"}, 32'(SerOut), 32'd1);
  endtask

  initial begin
    bitq_t basic_exp, zero_exp, max_exp, q;
    logic held;

    rst = 1'b1; Clk_EN = 1'b0; start = 1'b0;
    port_sel = 2'd0; len = 4'd0; payload = 15'd0;
    basic_exp = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    zero_exp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    max_exp   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int j = 0; j < 15; j++) max_exp.push_back((j % 2 == 0) ? 1'b1 : 1'b0);
`ifdef TX_PARITY_EN
    basic_exp.push_back(1'b1);
    zero_exp.push_back(1'b0);
    max_exp.push_back(1'b1);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // pin the model against hand-computed frames
    q = make_frame(2'b10, 4'd3, 15'b101);
    check("model_basic_len", 32'(q.size()), 32'(basic_exp.size()));
    for (int k = 0; k < q.size() && k < basic_exp.size(); k++)
      check("model_basic_bit", 32'(q[k]), 32'(basic_exp[k]));
    q = make_frame(2'd3, 4'd0, 15'h7fff);
    check("model_zero_len", 32'(q.size()), 32'(zero_exp.size()));
    for (int k = 0; k < q.size() && k < zero_exp.size(); k++)
      check("model_zero_bit", 32'(q[k]), 32'(zero_exp[k]));

    // reset idle with Clk_EN toggling and no start
    for (int i = 0; i < 50; i++) begin
      Clk_EN = ~Clk_EN;
      @(negedge clk);
      check("idle_ser", 32'(SerOut), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
    end
    Clk_EN = 1'b0;

    directed("basic", 2'b10, 4'd3, 15'b101, basic_exp);
    directed("zero", 2'd3, 4'd0, 15'h7fff, zero_exp);
    directed("max", 2'b01, 4'd15, 15'h5555, max_exp);

    // ignored start during DATA, then a 100-cycle stall
    port_sel = 2'd1; len = 4'd5; payload = 15'h0013; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) pulse(0);
    port_sel = 2'd2; len = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    held = SerOut;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("stall_ser", 32'(SerOut), 32'(held));
    end
    for (int k = 0; k < 4; k++) begin
      check("stall_busy", 32'(busy), 32'd1);
      pulse(0);
    end
`ifdef TX_PARITY_EN
    pulse(0);
`endif
    check("stall_done", 32'(done), 32'd1);
    @(negedge clk);
    check("no_queue", 32'(busy), 32'd0);

    // async reset while in COUNT, outputs must drop without a clock edge
    port_sel = 2'b10; len = 4'd3; payload = 15'b101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) pulse(0);
    check("pre_rst_ser", 32'(SerOut), 32'd0);
    #3 rst = 1'b1;
    #1;
    check("arst_ser", 32'(SerOut), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_remain", 32'(remain), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    directed("post_rst", 2'b10, 4'd3, 15'b101, basic_exp);

    // randomized traffic, checked every cycle by the model
    n_frames = 0;
    for (int i = 0; i < 4000; i++) begin
      Clk_EN   = ($urandom_range(0, 2) == 0);
      start    = ($urandom_range(0, 9) == 0);
      port_sel = 2'($urandom_range(0, 3));
      len      = 4'($urandom_range(0, 15));
      payload  = 15'($urandom);
      rst      = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    rst = 1'b0; Clk_EN = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rand_frames_seen", 32'(n_frames > 20), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_mux_tx.md
Name: serial_mux_tx

Overview:
- Transmit end of the serial port-demux link: serialises one frame {start bit, 2-bit port number, 4-bit data count, count data bits} onto a single line.
- The frame matches the format the receiver datapath decodes and routes to p0..p3.
- Sits on the sending board; bit advance is gated by a one-cycle step enable (one-pulser output or a baud tick), so frames can be stepped by push button on the lab board.

Parameters:
PORT_W, 2, width of port-number field (4 destination ports)
CNT_W, 4, width of data-count field; max payload bits = 2**CNT_W-1 = 15
IDLE_LVL, 1'b1, line level when idle; start bit is ~IDLE_LVL

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
Clk_EN  input  1  one-cycle step pulse; each pulse advances the line by one bit
start  input  1  frame request, sampled only in IDLE
port_sel  input  PORT_W  destination port, latched on accepted start
len  input  CNT_W  number of data bits (0..15), latched on accepted start
payload  input  2**CNT_W-1  data bits, bit 0 sent first, latched on accepted start
SerOut  output  1  serial line
busy  output  1  high from accepted start until frame end
done  output  1  one-clk pulse when last bit's step completes
remain  output  CNT_W  data bits still to send (for SSD display)

Behaviour:
- Reset, asynchronous and mid-frame included: state=IDLE, SerOut=IDLE_LVL, busy=0, done=0, remain=0, all latches cleared. Any frame in progress is dropped; the line returns to idle immediately.
- States: IDLE, START, PORT, COUNT, DATA (plus PARITY with the option below).
- IDLE: SerOut=IDLE_LVL. When start=1, latch port_sel/len/payload and go to START next clk. busy=1 and SerOut=~IDLE_LVL from that edge. Clk_EN in the same cycle is ignored.
- START: on Clk_EN go to PORT with bit index=PORT_W-1.
- PORT: SerOut = port bit [index], MSB first. On Clk_EN decrement the index; after bit 0 go to COUNT with index=CNT_W-1.
- COUNT: SerOut = len bit [index], MSB first. On Clk_EN after bit 0:
  - len=0: frame end.
  - otherwise: go to DATA, remain=len.
- DATA: SerOut = payload shift register bit 0. On Clk_EN shift right and decrement remain. Frame ends when remain goes 1->0.
- Frame end: next state IDLE, SerOut=IDLE_LVL, busy=0, done=1 for exactly one clk.
- Frame length in Clk_EN pulses = 1+PORT_W+CNT_W+len (7+len at defaults).
- start while busy: ignored, not queued. start in the done cycle (state already IDLE): accepted.
- Clk_EN only advances; without it every output holds indefinitely.
- remain: unsigned, never wraps below 0. Payload bits above len-1 are never transmitted.

Optional Feature:
- Macro TX_PARITY_EN.
- Defined: after the last DATA bit (or after COUNT when len=0), enter PARITY and send one even-parity bit over the transmitted port, count and data bits. Frame end follows that bit's Clk_EN; frame length is 8+len pulses.
- Undefined: no PARITY state, and the frame is exactly as above.

Decomposition:
- Shared package: state enum (IDLE, START, PORT, COUNT, DATA, PARITY), default PORT_W/CNT_W constants, and the IDLE_LVL constant. The receiver datapath imports the same package.
- One sub-module: tx_shift_reg (parallel load, right shift on enable, async reset), used for the payload. Reuse the existing shift-register style.

Test Plan:
- Reset idle: rst pulse, no start -> SerOut=1, busy=0, done=0, remain=0 for 50 clks, even with Clk_EN toggling.
- Basic frame: port_sel=2'b10, len=3, payload=15'b101, start, then 10 Clk_EN pulses -> SerOut per step 0,1,0,0,0,1,1,1,0,1. done pulses once on the 10th step. remain runs 3,2,1,0.
- Zero length: port_sel=3, len=0, start, 7 pulses -> 0,1,1,0,0,0,0. done after the 7th pulse. DATA never entered.
- Max length: len=15, payload=15'h5555 -> 22-pulse frame, data bits alternate 1,0,... starting with 1. remain reaches 0 with no wrap.
- Ignored start / stall: start re-asserted during the DATA state -> no effect, and the next frame starts only after done. Clk_EN held low for 100 clks mid-frame -> SerOut constant.
- Async reset mid-frame: rst asserted while in COUNT -> SerOut=1 and busy=0 without a clock edge. The following start sends a clean full frame. With TX_PARITY_EN, the basic frame adds parity=1 (ones count 1+1+1+2=5, odd).
